// File: rtl/serializer_if.sv
// serializer_if: word handshake between the sample source and the serializer
interface serializer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;

    modport master (output data_in, data_valid, input data_ready);
    modport slave  (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/serializer.sv
// serializer: double-buffered MSB-first word-to-bit serializer for the audio output
module serializer #(
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          enable,
    serializer_if.slave   bus,
    output logic          pdm_o,
    output logic          aud_sd_o,
    output logic          word_done,
    output logic          underrun
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    typedef enum logic [1:0] {IDLE, RUN, STARVE} state_t;

    state_t           state;
    logic [WIDTH-1:0] buf_q;
    logic             buf_full;
    logic [WIDTH-1:0] sh;
    logic [CW-1:0]    cnt;
    logic             load;

    assign bus.data_ready = ~buf_full;
    assign load = enable && buf_full && (state != RUN || cnt == LAST);

    // holding buffer: accepts whenever empty, emptied only by a load into the shifter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            buf_q    <= '0;
            buf_full <= 1'b0;
        end else if (load) begin
            buf_full <= 1'b0;
        end else if (bus.data_valid && !buf_full) begin
            buf_q    <= bus.data_in;
            buf_full <= 1'b1;
        end
    end

    // shifter FSM with registered serial output, word strobe and sticky underrun
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh        <= '0;
            cnt       <= '0;
            pdm_o     <= 1'b0;
            aud_sd_o  <= 1'b0;
            word_done <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            aud_sd_o <= enable;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                pdm_o     <= 1'b0;
                word_done <= 1'b0;
                underrun  <= 1'b0;
            end else if (load) begin
                state     <= RUN;
                sh        <= buf_q;
                cnt       <= '0;
                pdm_o     <= buf_q[WIDTH-1];
                word_done <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (cnt == LAST) begin
                            state     <= STARVE;
                            underrun  <= 1'b1;
                            pdm_o     <= 1'b0;
                            word_done <= 1'b0;
                        end else begin
                            sh        <= sh << 1;
                            pdm_o     <= sh[WIDTH-2];
                            cnt       <= cnt + CW'(1);
                            word_done <= (cnt == PENULT);
                        end
                    end
                    STARVE: begin
                        pdm_o     <= ~pdm_o;
                        word_done <= 1'b0;
                    end
                    default: begin
                        pdm_o     <= 1'b0;
                        word_done <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
